// File: rtl/dsp_mac_stage.sv
// Four-stage pre-add / multiply / post-add MAC. Latency is 4 enabled cycles, one op per cycle.
// No backpressure: ce=0 freezes every register, and acc_clr clears P while stages 1-3 keep moving.
module dsp_mac_stage #(
  parameter int A_WIDTH = 18,
  parameter int P_WIDTH = 48
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic                        valid_in,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [A_WIDTH-1:0]   b,
  input  logic signed [A_WIDTH-1:0]   d,
  input  logic        [P_WIDTH-1:0]   c,
  input  logic        [3:0]           opmode,
  input  logic                        use_c,
  input  logic                        acc_clr,
  output logic        [P_WIDTH-1:0]   p,
  output logic                        carryout,
  output logic                        valid_out
);

  localparam int M_WIDTH = 2 * A_WIDTH;

  // Stage 1: input registers
  logic signed [A_WIDTH-1:0] a1, b1, d1;
  logic        [P_WIDTH-1:0] c1;
  logic        [3:0]         op1;
  logic                      usec1;
  logic                      v1;

  // Stage 2: pre-adder result plus delayed operands/controls
  logic signed [A_WIDTH-1:0] pre2, a2;
  logic        [P_WIDTH-1:0] c2;
  logic        [1:0]         op2;
  logic                      usec2;
  logic                      v2;

  // Stage 3: M register plus delayed controls
  logic signed [M_WIDTH-1:0] m3;
  logic        [P_WIDTH-1:0] c3;
  logic        [1:0]         op3;
  logic                      usec3;
  logic                      v3;

  logic signed [A_WIDTH-1:0] pre_nxt;
  logic signed [M_WIDTH-1:0] a_ext, pre_ext, m_nxt;
  logic        [P_WIDTH-1:0] m_ext, z;
  logic        [P_WIDTH:0]   sum;

  always_comb begin
    pre_nxt = b1;
    if (op1[0]) begin
      if (op1[1]) pre_nxt = d1 - b1;
      else        pre_nxt = d1 + b1;
    end
  end

  // Low M_WIDTH bits of the product of sign-extended operands equal the signed product.
  always_comb begin
    a_ext   = {{A_WIDTH{a2[A_WIDTH-1]}}, a2};
    pre_ext = {{A_WIDTH{pre2[A_WIDTH-1]}}, pre2};
    m_nxt   = a_ext * pre_ext;
  end

  generate
    if (P_WIDTH > M_WIDTH) begin : g_mext
      assign m_ext = {{(P_WIDTH-M_WIDTH){m3[M_WIDTH-1]}}, m3};
    end else begin : g_mdirect
      assign m_ext = m3;
    end
  endgenerate

  always_comb begin
    z = '0;
    if (op3[0])    z = p;
    else if (usec3) z = c3;
    if (op3[1]) sum = {1'b0, z} - {1'b0, m_ext};
    else        sum = {1'b0, z} + {1'b0, m_ext};
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      a1    <= a;
      b1    <= b;
      d1    <= d;
      c1    <= c;
      op1   <= opmode;
      usec1 <= use_c;
      pre2  <= pre_nxt;
      a2    <= a1;
      c2    <= c1;
      op2   <= op1[3:2];
      usec2 <= usec1;
      c3    <= c2;
      op3   <= op2;
      usec3 <= usec2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      m3 <= '0;
    end else if (ce) begin
      v1 <= valid_in;
      v2 <= v1;
      v3 <= v2;
      m3 <= m_nxt;
    end
  end

  // acc_clr wins over a simultaneous stage-3 result, which is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p         <= '0;
      carryout  <= 1'b0;
      valid_out <= 1'b0;
    end else if (ce) begin
      if (acc_clr) begin
        p         <= '0;
        carryout  <= 1'b0;
        valid_out <= 1'b0;
      end else begin
        valid_out <= v3;
        if (v3) begin
          p        <= sum[P_WIDTH-1:0];
          carryout <= sum[P_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_stage.sv
// Directed/random bench for dsp_mac_stage with a queue-based scoreboard and reference model.
module tb_dsp_mac_stage;

  logic               clk;
  logic               rst_n;
  logic               ce;
  logic               valid_in;
  logic signed [17:0] a, b, d;
  logic        [47:0] c;
  logic        [3:0]  opmode;
  logic               use_c;
  logic               acc_clr;
  logic        [47:0] p;
  logic               carryout;
  logic               valid_out;

  typedef struct {
    logic signed [17:0] a, b, d;
    logic        [47:0] c;
    logic        [3:0]  op;
    logic               use_c;
    int                 due;
  } op_t;

  op_t         q[$];
  int          errors = 0;
  int          checks = 0;
  int          ecyc = 0;
  logic [47:0] mdl_p = '0;

  dsp_mac_stage #(.A_WIDTH(18), .P_WIDTH(48)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .valid_in(valid_in),
    .a(a), .b(b), .d(d), .c(c), .opmode(opmode), .use_c(use_c),
    .acc_clr(acc_clr), .p(p), .carryout(carryout), .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {carry, p} for one operation given the accumulator value.
  function automatic logic [48:0] model(input op_t o, input logic [47:0] pz);
    logic signed [17:0] pre;
    logic signed [35:0] ae, pe, m;
    logic        [47:0] mx, z;
    if (!o.op[0])     pre = o.b;
    else if (o.op[1]) pre = o.d - o.b;
    else              pre = o.d + o.b;
    ae = {{18{o.a[17]}}, o.a};
    pe = {{18{pre[17]}}, pre};
    m  = ae * pe;
    mx = {{12{m[35]}}, m};
    if (o.op[2])      z = pz;
    else if (o.use_c) z = o.c;
    else              z = '0;
    if (o.op[3]) return {1'b0, z} - {1'b0, mx};
    else         return {1'b0, z} + {1'b0, mx};
  endfunction

  task automatic tick();
    logic        ce_e, acc_e, vo_prev;
    logic [47:0] p_prev;
    logic [48:0] r;
    op_t         o;
    ce_e    = ce;
    acc_e   = acc_clr;
    p_prev  = p;
    vo_prev = valid_out;
    if (ce && valid_in) begin
      o.a = a; o.b = b; o.d = d; o.c = c; o.op = opmode; o.use_c = use_c;
      o.due = ecyc + 4;
      q.push_back(o);
    end
    @(posedge clk);
    #1;
    if (ce_e) begin
      ecyc++;
      if (acc_e) begin
        chk("clr_p", 64'(p), 64'd0);
        chk("clr_carry", 64'(carryout), 64'd0);
        chk("clr_valid", 64'(valid_out), 64'd0);
        mdl_p = '0;
        while (q.size() > 0 && q[0].due <= ecyc) void'(q.pop_front());
      end else if (valid_out) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          o = q.pop_front();
          r = model(o, mdl_p);
          mdl_p = r[47:0];
          chk("latency", 64'(ecyc), 64'(o.due));
          chk("p", 64'(p), 64'(r[47:0]));
          chk("carry", 64'(carryout), 64'(r[48]));
        end
      end else begin
        chk("p_bubble_hold", 64'(p), 64'(mdl_p));
        if (q.size() > 0 && q[0].due <= ecyc) begin
          chk("missing_valid", 64'd0, 64'd1);
          void'(q.pop_front());
        end
      end
    end else begin
      chk("ce_hold_p", 64'(p), 64'(p_prev));
      chk("ce_hold_valid", 64'(valid_out), 64'(vo_prev));
    end
  endtask

  task automatic set_op(input logic signed [17:0] ta, tb, td, input logic [47:0] tc,
                        input logic [3:0] top, input logic tu);
    a = ta; b = tb; d = td; c = tc; opmode = top; use_c = tu; valid_in = 1'b1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; valid_in = 1'b0; acc_clr = 1'b0;
    a = '0; b = '0; d = '0; c = '0; opmode = '0; use_c = 1'b0;
    #2;
    chk("reset_p", 64'(p), 64'd0);
    chk("reset_carry", 64'(carryout), 64'd0);
    chk("reset_valid", 64'(valid_out), 64'd0);
    #20 rst_n = 1'b1;
    idle(2);

    // (3*(5+4)) with no post-add operand
    set_op(18'sd3, 18'sd4, 18'sd5, 48'd0, 4'b0001, 1'b0);
    tick();
    idle(5);
    chk("req33_p", 64'(p), 64'd27);
    chk("req33_carry", 64'(carryout), 64'd0);

    acc_clr = 1'b1; tick(); acc_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_op(18'sd2, 18'sd1, 18'sd0, 48'd0, 4'b0100, 1'b0);
      tick();
    end
    idle(5);
    chk("req34_p", 64'(p), 64'd10);
    ce = 1'b0; acc_clr = 1'b1; tick();
    chk("clr_no_ce_p", 64'(p), 64'd10);
    ce = 1'b1; tick(); acc_clr = 1'b0;
    chk("req34_clr_p", 64'(p), 64'd0);

    set_op(18'sd1, 18'sd20, 18'sd0, 48'd10, 4'b1000, 1'b1);
    tick();
    idle(5);
    chk("req35_p", 64'(p), 64'hFFFF_FFFF_FFF6);
    chk("req35_borrow", 64'(carryout), 64'd1);

    set_op(18'sd1, 18'sd1, 18'h1FFFF, 48'd0, 4'b0001, 1'b0);
    tick();
    idle(5);
    chk("req36_p", 64'(p), 64'hFFFF_FFFE_0000);

    // Back-to-back mixed ops with a 3-cycle ce stall in the middle
    for (int i = 0; i < 12; i++) begin
      set_op(18'($urandom), 18'($urandom), 18'($urandom),
             {16'($urandom), 32'($urandom)}, 4'($urandom), 1'($urandom));
      ce = !(i >= 4 && i <= 6);
      tick();
    end
    ce = 1'b1;
    idle(6);

    // Reset between edges with three operations in flight
    for (int i = 0; i < 3; i++) begin
      set_op(18'sd7, 18'sd3, 18'sd2, 48'd5, 4'b0101, 1'b1);
      tick();
    end
    valid_in = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("req38_p", 64'(p), 64'd0);
    chk("req38_valid", 64'(valid_out), 64'd0);
    chk("req38_carry", 64'(carryout), 64'd0);
    q.delete();
    mdl_p = '0;
    #2 rst_n = 1'b1;
    idle(6);

    set_op(-18'sd4, 18'sd6, 18'sd1, 48'd0, 4'b0011, 1'b0);
    tick();
    idle(6);
    chk("req32_p", 64'(p), 64'd20);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsp_mac_stage.md
DSP_MAC_STAGE -- requirements
Module: dsp_mac_stage

Interface
REQ-001 Parameter A_WIDTH, default 18, width of A, B and D operands and of the pre-adder result.
REQ-002 Parameter P_WIDTH, default 48, width of C, the post-adder and P; SHALL be at least 2*A_WIDTH.
REQ-003 Port clk, input, 1, the single clock; all state SHALL change only on its rising edge, except on reset.
REQ-004 Port rst_n, input, 1, the reset; it SHALL be asynchronous and active-low.
REQ-005 Port ce, input, 1, global clock enable; when 0, every register SHALL hold.
REQ-006 Port valid_in, input, 1, qualifies the operand and opmode inputs sampled on this cycle.
REQ-007 Ports a, b, d, input, A_WIDTH each, signed two's-complement operands.
REQ-008 Port c, input, P_WIDTH, signed post-adder operand.
REQ-009 Port opmode, input, 4: bit0 preadd_en, bit1 preadd_sub, bit2 acc_en, bit3 post_sub.
REQ-010 Port use_c, input, 1, selects c as the post-adder Z operand when acc_en=0.
REQ-011 Port acc_clr, input, 1, synchronous accumulator clear, qualified by ce.
REQ-012 Port p, output, P_WIDTH, registered result.
REQ-013 Port carryout, output, 1, registered carry or borrow of the post-adder.
REQ-014 Port valid_out, output, 1, high for one enabled cycle per accepted valid_in.

Function
REQ-015 Stage 1 SHALL register a, b, d, c, opmode, use_c and valid_in when ce=1.
REQ-016 Stage 2 SHALL register the pre-adder result and delay A, C, the control bits and valid by one stage.
REQ-017 The pre-adder result SHALL be b when preadd_en=0, d+b when preadd_en=1 and preadd_sub=0, and d-b when preadd_en=1 and preadd_sub=1.
REQ-018 The pre-adder result SHALL be truncated to A_WIDTH bits, wrapping with no saturation.
REQ-019 Stage 3 (M register) SHALL hold the signed product of A and the pre-adder result, 2*A_WIDTH bits wide.
REQ-020 M SHALL be sign-extended to P_WIDTH before entering the post-adder.
REQ-021 Stage 4 (P register) SHALL select Z as p when acc_en=1, as the delayed c when acc_en=0 and use_c=1, and as 0 otherwise.
REQ-022 Stage 4 SHALL compute P = Z+M when post_sub=0 and P = Z-M when post_sub=1, modulo 2^P_WIDTH with wrap-around.
REQ-023 carryout SHALL be bit P_WIDTH of the unsigned (P_WIDTH+1)-bit add or subtract, i.e. carry on add and borrow (Z<M unsigned) on subtract.
REQ-024 p and carryout SHALL update only when ce=1 and stage-3 valid=1; otherwise they hold.
REQ-025 Latency SHALL be 4 enabled cycles from valid_in to valid_out, with throughput of one operation per enabled cycle.
REQ-026 Bubbles (valid_in=0) SHALL propagate as valid=0 and SHALL NOT alter p.
REQ-027 When ce=1 and acc_clr=1, p and carryout SHALL go to 0 and valid_out SHALL go to 0, regardless of a simultaneous stage-3 valid; stages 1-3 SHALL continue to advance.
REQ-028 acc_clr with ce=0 SHALL have no effect.
REQ-029 Data registers are not required to reset; valid bits SHALL always reset.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately clear p, carryout, valid_out, all internal valid bits and the M register to 0, without waiting for clk.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations, and no valid_out SHALL follow for them.
REQ-032 After rst_n is released, the first valid_out SHALL appear exactly 4 enabled cycles after the first accepted valid_in.

Verification
REQ-033 a=3, b=4, d=5, opmode=0001 (d+b), use_c=0, one valid pulse -> 4 cycles later valid_out=1, p=27, carryout=0.
REQ-034 a=2, b=1 with opmode=0100 (accumulate), held valid for 5 cycles, p=0 initially -> p steps 2, 4, 6, 8, 10; then acc_clr -> p=0, valid_out=0.
REQ-035 c=10, a=1, b=20, use_c=1, opmode=1000 -> p = 2^48 - 10 (i.e. -10), carryout=1 (borrow).
REQ-036 a=1, d=0x1FFFF, b=1, opmode=0001 -> the pre-adder wraps to -0x20000 and p = sign-extended -131072.
REQ-037 ce held at 0 for 3 cycles mid-stream -> p and valid_out hold, and valid_out resumes so that total latency equals 4 enabled cycles.
REQ-038 rst_n pulsed low between clock edges with 3 operations in flight -> p=0 and valid_out=0 immediately, and no stale valid_out follows.
